tone_mixer: RTL and testbench
=============================

TONE_MIXER -- requirements
Module: tone_mixer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single block clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_C, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port SAMPLE_EN, input, 1 bit: one-cycle strobe to capture channel levels (driven from the FCLK_16 enable domain).
REQ-004 SHALL have ports CH0, CH1, CH2, CH3, input, 4 bits each: tone generator DOUT levels, unsigned.
REQ-005 SHALL have port DIN, input, 4 bits: volume write data.
REQ-006 SHALL have port VSEL, input, 4 bits: per-channel volume write strobe; bit n writes channel n volume.
REQ-007 SHALL have port MUTE, input, 1 bit: level-sensitive output mute.
REQ-008 SHALL have port MIX, output, 6 bits: mixed sample, unsigned.
REQ-009 SHALL have port MIX_VALID, output, 1 bit: one-cycle pulse when MIX updates.
REQ-010 SHALL have port PWM, output, 1 bit: PWM DAC output of MIX.

Function
REQ-011 Volume regs VOL0..VOL3 (4 bits each) SHALL load DIN on any cycle where the matching VSEL bit is 1; several bits set SHALL write all selected regs.
REQ-012 A volume write in cycle N SHALL be visible to the product stage from cycle N+1.
REQ-013 Stage 0: on SAMPLE_EN=1, CH0..CH3 SHALL be registered; with SAMPLE_EN=0 the capture regs SHALL hold.
REQ-014 Stage 1 (cycle after capture): P_n = (CH_n * VOL_n) >> 4, 8-bit product truncated to 4 bits (max 14); all products SHALL be registered.
REQ-015 Stage 2: MIX = P0+P1+P2+P3 (max 56, no overflow in 6 bits), or 0 when MUTE=1 in that cycle.
REQ-016 Latency SHALL be exactly 2 cycles: SAMPLE_EN in cycle N gives new MIX and MIX_VALID=1 in cycle N+2.
REQ-017 Pipeline SHALL accept SAMPLE_EN on every cycle, no stalls; back-to-back strobes give back-to-back MIX_VALID pulses.
REQ-018 MIX SHALL hold its value between MIX_VALID pulses.
REQ-019 PWM counter: 6-bit free-running, increments every cycle, wraps 63->0.
REQ-020 PWM duty reg SHALL load MIX only in the cycle the counter equals 63, so duty changes only at period boundaries.
REQ-021 PWM SHALL be 1 when counter < duty, else 0 (registered); duty 0 gives constant 0; duty 56 gives 56 high cycles of 64.
REQ-022 MIX updating in the same cycle the counter is 63: the duty reg SHALL take the MIX value present before that update.

Reset
REQ-023 While RST_C=0, all regs SHALL clear asynchronously: VOL0..3=4'hF, capture regs=0, products=0, MIX=0, MIX_VALID=0, PWM counter=0, duty=0, PWM=0.
REQ-024 Reset asserted mid-pipeline SHALL discard in-flight samples; no MIX_VALID pulse for them after release.
REQ-025 After RST_C rises, the first MIX_VALID SHALL occur 2 cycles after the first SAMPLE_EN.

Structure
REQ-026 Package tone_mixer_pkg SHALL hold NUM_CH=4, CH_W=4, VOL_W=4, MIX_W=6, PWM_W=6, and VOL_RESET=4'hF.
REQ-027 PWM counter, duty reg and comparator SHALL live in sub-module pwm_dac (inputs CLK, RST_C, DUTY[5:0]; output PWM).
REQ-028 Mixer datapath SHALL be parameterised on NUM_CH; total RTL 120-400 lines.

Verification
REQ-029 After reset: CH0..3=4'hF, SAMPLE_EN pulse at cycle 0 -> MIX=56 with MIX_VALID at cycle 2; next PWM period high 56 of 64 cycles.
REQ-030 VSEL=4'b0010, DIN=4'h8; CH1=4'hA, others 0, SAMPLE_EN -> MIX=5 (10*8=80, >>4=5).
REQ-031 VSEL write and SAMPLE_EN in the same cycle: the product uses the old volume; a second SAMPLE_EN one cycle later uses the new volume.
REQ-032 SAMPLE_EN held high 4 cycles with changing CH values -> 4 consecutive MIX_VALID pulses with the matching MIX values in order.
REQ-033 MUTE=1 during stage 2 -> MIX=0 with MIX_VALID still pulsed; PWM reaches constant 0 within one period plus one cycle.
REQ-034 RST_C pulled low one cycle after SAMPLE_EN -> MIX stays 0, no MIX_VALID, VOL regs return to 4'hF.

Source files
------------

// File: rtl/tone_mixer_pkg.sv
// rtl/tone_mixer_pkg.sv - shared widths, types and the level scaling helper for tone_mixer
package tone_mixer_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 4;
  localparam int VOL_W  = 4;
  localparam int MIX_W  = 6;
  localparam int PWM_W  = 6;
  localparam int PROD_W = CH_W;

  localparam logic [VOL_W-1:0] VOL_RESET = 4'hF;

  typedef logic [CH_W-1:0]   levelT;
  typedef logic [VOL_W-1:0]  volT;
  typedef logic [PROD_W-1:0] prodT;
  typedef logic [MIX_W-1:0]  mixT;

  // Full-width product, keeping only the upper nibble (level * vol / 16).
  function automatic prodT scaleLevel(input levelT lvl, input volT vol);
    logic [CH_W+VOL_W-1:0] full;
    full = {{VOL_W{1'b0}}, lvl} * {{CH_W{1'b0}}, vol};
    return full[CH_W+VOL_W-1 -: PROD_W];
  endfunction

endpackage

// File: rtl/tone_mixer_pwm_dac.sv
// rtl/tone_mixer_pwm_dac.sv - free-running PWM DAC with period-boundary duty reload
module pwm_dac
  import tone_mixer_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_C,
  input  logic [PWM_W-1:0] DUTY,
  output logic             PWM
);

  localparam logic [PWM_W-1:0] PERIOD_END = '1;

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty;

  // Duty only reloads on the last count so a period is never split between two levels.
  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      cnt  <= '0;
      duty <= '0;
      PWM  <= 1'b0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      if (cnt == PERIOD_END) begin
        duty <= DUTY;
      end
      PWM <= (cnt < duty);
    end
  end

endmodule

// File: rtl/tone_mixer.sv
// rtl/tone_mixer.sv - four-channel volume-scaled tone mixer with 2-cycle pipeline and PWM output
module tone_mixer
  import tone_mixer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_C,
  input  logic              SAMPLE_EN,
  input  logic [CH_W-1:0]   CH0,
  input  logic [CH_W-1:0]   CH1,
  input  logic [CH_W-1:0]   CH2,
  input  logic [CH_W-1:0]   CH3,
  input  logic [VOL_W-1:0]  DIN,
  input  logic [NUM_CH-1:0] VSEL,
  input  logic              MUTE,
  output logic [MIX_W-1:0]  MIX,
  output logic              MIX_VALID,
  output logic              PWM
);

  levelT chIn    [NUM_CH];
  volT   vol     [NUM_CH];
  volT   volSnap [NUM_CH];
  levelT chCap   [NUM_CH];
  prodT  prod    [NUM_CH];
  logic  capValid;
  logic  prodValid;
  mixT   mixSum;

  assign chIn[0] = CH0;
  assign chIn[1] = CH1;
  assign chIn[2] = CH2;
  assign chIn[3] = CH3;

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      for (int n = 0; n < NUM_CH; n++) begin
        vol[n] <= VOL_RESET;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (VSEL[n]) begin
          vol[n] <= DIN;
        end
      end
    end
  end

  // Volumes are snapshotted with the levels so a write coinciding with a strobe
  // only affects the following sample.
  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      capValid <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        chCap[n]   <= '0;
        volSnap[n] <= '0;
      end
    end else begin
      capValid <= SAMPLE_EN;
      if (SAMPLE_EN) begin
        for (int n = 0; n < NUM_CH; n++) begin
          chCap[n]   <= chIn[n];
          volSnap[n] <= vol[n];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      prodValid <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        prod[n] <= '0;
      end
    end else begin
      prodValid <= capValid;
      if (capValid) begin
        for (int n = 0; n < NUM_CH; n++) begin
          prod[n] <= scaleLevel(chCap[n], volSnap[n]);
        end
      end
    end
  end

  always_comb begin
    mixSum = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      mixSum = mixSum + mixT'(prod[n]);
    end
  end

  always_ff @(posedge CLK or negedge RST_C) begin
    if (!RST_C) begin
      MIX       <= '0;
      MIX_VALID <= 1'b0;
    end else begin
      MIX_VALID <= prodValid;
      if (prodValid) begin
        MIX <= MUTE ? '0 : mixSum;
      end
    end
  end

  pwm_dac pwmDac (
    .CLK   (CLK),
    .RST_C (RST_C),
    .DUTY  (MIX),
    .PWM   (PWM)
  );

endmodule

// File: tb/tb_tone_mixer.sv
// tb/tb_tone_mixer.sv - self-checking bench for tone_mixer
module tb_tone_mixer;

  logic       CLK = 1'b0;
  logic       RST_C = 1'b0;
  logic       SAMPLE_EN = 1'b0;
  logic       MUTE = 1'b0;
  logic [3:0] CH0 = '0, CH1 = '0, CH2 = '0, CH3 = '0;
  logic [3:0] DIN = '0;
  logic [3:0] VSEL = '0;
  logic [5:0] MIX;
  logic       MIX_VALID;
  logic       PWM;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 CLK = ~CLK;

  tone_mixer dut (
    .CLK       (CLK),
    .RST_C     (RST_C),
    .SAMPLE_EN (SAMPLE_EN),
    .CH0       (CH0),
    .CH1       (CH1),
    .CH2       (CH2),
    .CH3       (CH3),
    .DIN       (DIN),
    .VSEL      (VSEL),
    .MUTE      (MUTE),
    .MIX       (MIX),
    .MIX_VALID (MIX_VALID),
    .PWM       (PWM)
  );

  task automatic check(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Reference model: samples become due two edges after their strobe; PWM
  // counter value equals the number of edges since reset modulo 64.
  typedef struct {
    int due;
    int val;
  } pendT;

  pendT pend[$];
  int   edgeIdx = 0;
  int   cntM = 0;
  int   dutyM = 0;
  int   expMix = 0;
  int   expValid = 0;
  int   expPwm = 0;
  int   volM[4] = '{15, 15, 15, 15};
  int   mixAcc;

  always @(posedge CLK) begin
    if (!RST_C) begin
      pend.delete();
      edgeIdx = 0;
      cntM = 0;
      dutyM = 0;
      expMix = 0;
      expValid = 0;
      expPwm = 0;
      for (int n = 0; n < 4; n++) volM[n] = 15;
    end else begin
      edgeIdx++;
      expPwm = (cntM < dutyM) ? 1 : 0;
      if (cntM == 63) dutyM = expMix;
      cntM = (cntM + 1) % 64;
      if (SAMPLE_EN) begin
        mixAcc = (int'(CH0) * volM[0]) / 16 + (int'(CH1) * volM[1]) / 16
               + (int'(CH2) * volM[2]) / 16 + (int'(CH3) * volM[3]) / 16;
        pend.push_back('{due: edgeIdx + 2, val: mixAcc});
      end
      for (int n = 0; n < 4; n++) if (VSEL[n]) volM[n] = int'(DIN);
      expValid = 0;
      if (pend.size() > 0 && pend[0].due == edgeIdx) begin
        expValid = 1;
        expMix = MUTE ? 0 : pend[0].val;
        void'(pend.pop_front());
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    check("cyc_mix_valid", int'(MIX_VALID), expValid);
    check("cyc_mix", int'(MIX), expMix);
    check("cyc_pwm", int'(PWM), expPwm);
  end

  int seen;
  int highs;

  initial begin
    repeat (3) tick();
    check("rst_mix", int'(MIX), 0);
    check("rst_valid", int'(MIX_VALID), 0);
    check("rst_pwm", int'(PWM), 0);
    RST_C = 1'b1;

    // Full-scale sample, full volume: 4 * 14 = 56
    {CH0, CH1, CH2, CH3} = 16'hFFFF;
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    check("lat_not_yet", int'(MIX_VALID), 0);
    tick();
    check("full_valid", int'(MIX_VALID), 1);
    check("full_mix", int'(MIX), 56);

    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick();
      if (PWM) seen = 1;
    end
    check("pwm_rise_seen", seen, 1);
    highs = int'(PWM);
    repeat (63) begin
      tick();
      highs += int'(PWM);
    end
    check("pwm_high_56", highs, 56);

    // Single-channel volume write: 10 * 8 / 16 = 5
    VSEL = 4'b0010;
    DIN = 4'h8;
    tick();
    VSEL = 4'b0000;
    {CH0, CH1, CH2, CH3} = 16'h0A00;
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    tick();
    check("vol8_valid", int'(MIX_VALID), 1);
    check("vol8_mix", int'(MIX), 5);

    // Write coinciding with strobe: old vol 8 -> 5, then new vol 4 -> 2
    VSEL = 4'b0010;
    DIN = 4'h4;
    SAMPLE_EN = 1'b1;
    tick();
    VSEL = 4'b0000;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    check("same_cyc_old_vol", int'(MIX), 5);
    tick();
    check("next_cyc_new_vol", int'(MIX), 2);
    check("next_cyc_valid", int'(MIX_VALID), 1);

    // Back-to-back strobes at full volume
    VSEL = 4'hF;
    DIN = 4'hF;
    tick();
    VSEL = 4'h0;
    SAMPLE_EN = 1'b1;
    {CH0, CH1, CH2, CH3} = 16'h1234;
    tick();
    {CH0, CH1, CH2, CH3} = 16'hF0F0;
    tick();
    {CH0, CH1, CH2, CH3} = 16'h5678;
    tick();
    check("b2b_0", int'(MIX), 6);
    {CH0, CH1, CH2, CH3} = 16'h0F07;
    tick();
    check("b2b_1", int'(MIX), 28);
    SAMPLE_EN = 1'b0;
    tick();
    check("b2b_2", int'(MIX), 22);
    tick();
    check("b2b_3", int'(MIX), 20);
    check("b2b_3_valid", int'(MIX_VALID), 1);
    tick();
    check("hold_valid", int'(MIX_VALID), 0);
    check("hold_mix", int'(MIX), 20);

    // Mute during the output stage
    {CH0, CH1, CH2, CH3} = 16'hFFFF;
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    MUTE = 1'b1;
    tick();
    check("mute_valid", int'(MIX_VALID), 1);
    check("mute_mix", int'(MIX), 0);
    repeat (65) tick();
    highs = 0;
    repeat (64) begin
      tick();
      highs += int'(PWM);
    end
    check("mute_pwm_zero", highs, 0);
    MUTE = 1'b0;

    // Reset one cycle after a strobe discards it and restores volumes
    VSEL = 4'hF;
    DIN = 4'h2;
    tick();
    VSEL = 4'h0;
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    RST_C = 1'b0;
    tick();
    tick();
    check("midrst_mix", int'(MIX), 0);
    check("midrst_valid", int'(MIX_VALID), 0);
    RST_C = 1'b1;
    highs = 0;
    repeat (4) begin
      tick();
      highs += int'(MIX_VALID);
    end
    check("midrst_no_pulse", highs, 0);
    SAMPLE_EN = 1'b1;
    tick();
    SAMPLE_EN = 1'b0;
    tick();
    check("post_rst_not_yet", int'(MIX_VALID), 0);
    tick();
    check("post_rst_valid", int'(MIX_VALID), 1);
    check("post_rst_vol_f", int'(MIX), 56);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
